// File: rtl/pcileech_cfg_mgmt_responder_if.sv
// Configuration-management handshake between the CFG handling block (master)
// and the emulated management port (slave).
interface pcileech_cfg_mgmt_responder_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] cfg_dwaddr;
    logic              cfg_rd_en;
    logic              cfg_wr_en;
    logic [31:0]       cfg_di;
    logic [3:0]        cfg_byte_en;
    logic [31:0]       cfg_do;
    logic              cfg_rd_wr_done;

    modport master (
        output cfg_dwaddr, cfg_rd_en, cfg_wr_en, cfg_di, cfg_byte_en,
        input  cfg_do, cfg_rd_wr_done
    );

    modport slave (
        input  cfg_dwaddr, cfg_rd_en, cfg_wr_en, cfg_di, cfg_byte_en,
        output cfg_do, cfg_rd_wr_done
    );
endinterface

// File: rtl/pcileech_cfg_mgmt_responder.sv
// Emulated PCIe cfg management port: dword config space with a read-only
// header, byte-merged writes, backdoor init port and clear-on-reset.
module pcileech_cfg_mgmt_responder #(
    parameter int ADDR_W    = 10,
    parameter int LATENCY   = 2,
    parameter int RO_DWORDS = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    pcileech_cfg_mgmt_responder_if.slave cfg,
    input  logic                  init_wr_en,
    input  logic [ADDR_W-1:0]     init_addr,
    input  logic [31:0]           init_data,
    output logic                  busy,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output logic                  err_both
);
    typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WAIT, S_DONE, S_GAP} state_t;

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] RO_LIM    = (ADDR_W + 1)'(RO_DWORDS);
    localparam logic [3:0]      WAIT_LOAD = 4'(LATENCY - 2);

    logic [31:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       di_q, di_d;
    logic [3:0]        be_q, be_d;
    logic              is_wr_q, is_wr_d;
    logic [3:0]        wait_q, wait_d;
    logic [15:0]       rd_cnt_q, rd_cnt_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;
    logic              err_q, err_d;
    logic [31:0]       do_hold_q, do_hold_d;

    logic [31:0]       mem_rd_q;
    logic              byp_q;
    logic [31:0]       byp_data_q;

    logic [31:0]       rd_val;
    logic [31:0]       mask;
    logic [31:0]       merged;
    logic              init_we;
    logic              commit_we;

    assign init_we = init_wr_en && (state_q != S_CLEAR) && !rst;
    // An init write landing on the same edge as the storage read is forwarded.
    assign rd_val  = byp_q ? byp_data_q : mem_rd_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mask
            assign mask[8*gi +: 8] = {8{be_q[gi]}};
        end
    endgenerate

    assign merged    = (rd_val & ~mask) | (di_q & mask);
    assign commit_we = (state_q == S_DONE) && is_wr_q && ({1'b0, addr_q} >= RO_LIM)
                       && !(init_we && (init_addr == addr_q)) && !rst;

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        addr_d    = addr_q;
        di_d      = di_q;
        be_d      = be_q;
        is_wr_d   = is_wr_q;
        wait_d    = wait_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_d     = err_q;
        do_hold_d = do_hold_q;
        case (state_q)
            S_CLEAR: begin
                clr_d = clr_q + 1'b1;
                if (&clr_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (cfg.cfg_rd_en || cfg.cfg_wr_en) begin
                    addr_d  = cfg.cfg_dwaddr;
                    di_d    = cfg.cfg_di;
                    be_d    = cfg.cfg_byte_en;
                    is_wr_d = cfg.cfg_wr_en;
                    if (cfg.cfg_rd_en && cfg.cfg_wr_en) err_d = 1'b1;
                    wait_d  = WAIT_LOAD;
                    state_d = (LATENCY == 1) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == 4'd0) state_d = S_DONE;
                else                wait_d  = wait_q - 4'd1;
            end
            S_DONE: begin
                state_d = S_GAP;
                if (is_wr_q) begin
                    wr_cnt_d = wr_cnt_q + 16'd1;
                end else begin
                    rd_cnt_d  = rd_cnt_q + 16'd1;
                    do_hold_d = rd_val;
                end
            end
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_q     <= 1'b0;
            do_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_q     <= err_d;
            do_hold_q <= do_hold_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        di_q    <= di_d;
        be_q    <= be_d;
        is_wr_q <= is_wr_d;
        wait_q  <= wait_d;
    end

    // Storage is read every cycle at the next captured address, so the value
    // is ready on entry to DONE for both read data and the write merge.
    always_ff @(posedge clk) begin
        mem_rd_q   <= mem[addr_d];
        byp_q      <= init_we && (init_addr == addr_d);
        byp_data_q <= init_data;
        if (state_q == S_CLEAR) begin
            mem[clr_q] <= '0;
        end else begin
            if (commit_we) mem[addr_q]    <= merged;
            if (init_we)   mem[init_addr] <= init_data;
        end
    end

    assign cfg.cfg_rd_wr_done = (state_q == S_DONE);
    assign cfg.cfg_do         = ((state_q == S_DONE) && !is_wr_q) ? rd_val : do_hold_q;
    assign busy               = (state_q == S_CLEAR);
    assign rd_count           = rd_cnt_q;
    assign wr_count           = wr_cnt_q;
    assign err_both           = err_q;
endmodule

// File: doc/pcileech_cfg_mgmt_responder.md
# pcileech_cfg_mgmt_responder

Emulated PCIe configuration-management responder: the target side of the cfg_dwaddr / cfg_rd_en / cfg_wr_en / cfg_byte_en / cfg_di → cfg_do / cfg_rd_wr_done handshake driven by the CFG handling block. It backs a 2^ADDR_W-dword configuration space in local storage, with a read-only header region, byte-enable-merged writes and a backdoor init port. It replaces the PCIe core's management port in simulation and in shadow-config builds, so the CFG handling block connects unchanged.

## Interface
Parameters:
- ADDR_W, 10, dword address width; storage depth 2^ADDR_W dwords.
- LATENCY, 2, cycles from request acceptance to done pulse; legal 1..15.
- RO_DWORDS, 16, dword addresses below this value are read-only on the cfg port.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_dwaddr  in  ADDR_W  dword address, held by the initiator until done.
- cfg_rd_en  in  1  read request level.
- cfg_wr_en  in  1  write request level.
- cfg_di  in  32  write data.
- cfg_byte_en  in  4  write byte enables; bit n covers cfg_di[8n+7:8n].
- cfg_do  out  32  read data, valid in the done cycle of a read.
- cfg_rd_wr_done  out  1  one-cycle completion pulse for read or write.
- init_wr_en  in  1  backdoor full-dword write, ignores the RO region.
- init_addr  in  ADDR_W  backdoor address.
- init_data  in  32  backdoor data.
- busy  out  1  high while clearing storage after reset.
- rd_count  out  16  accepted reads, wraps at 16'hFFFF→0.
- wr_count  out  16  accepted writes, wraps.
- err_both  out  1  sticky: rd_en and wr_en were seen together at acceptance.

## Operation
- States: CLEAR, IDLE, WAIT, DONE, GAP.
- CLEAR: entered on rst. A clear counter walks addresses 0..2^ADDR_W-1 writing 0, one per cycle, and busy=1. Cfg requests are not accepted and init writes are ignored. After the last address, the block goes to IDLE and busy drops.
- IDLE: if cfg_rd_en|cfg_wr_en, capture addr, di, byte_en and type, then go to WAIT. Type is write when wr_en=1, read otherwise. If both enables are high, treat the request as a write and set err_both.
- WAIT: count LATENCY-1 cycles, then go to DONE. With LATENCY=1, go straight from IDLE to DONE.
- DONE: cfg_rd_wr_done=1 for exactly this cycle.
  - Read: cfg_do = storage[captured addr] and rd_count increments.
  - Write: wr_count increments and the write commits here when captured addr ≥ RO_DWORDS. Commit value is new = (old & ~M) | (di & M), where M expands byte_en to 32 bits.
  - Write with byte_en=0, or to an RO address: completes normally with storage unchanged.
- GAP: one cycle with enables ignored. This absorbs the initiator's registered enable clear. Then go to IDLE.
- cfg_do holds its last read value outside DONE. Writes do not change cfg_do.
- Init port: active in every state except CLEAR and writes full dwords at any address.
  - Same cycle and same address as a DONE write commit: init wins and the cfg write is dropped. wr_count still increments and done still pulses.
  - Different addresses: both writes take effect.
- A read in DONE at the address of a same-cycle init write returns the pre-write value.

## Timing
- Reset values: cfg_do=0, cfg_rd_wr_done=0, busy=1, rd_count=0, wr_count=0, err_both=0, state=CLEAR.
- rst asserted in any state: at the next edge done=0, any in-flight request is dropped without completion, and the counters and err_both clear. CLEAR restarts from address 0.
- The first request can be accepted 2^ADDR_W+1 cycles after the rst deassertion edge.
- Request seen in IDLE at edge T: done is high during cycle T+LATENCY.
- Next acceptance is no earlier than T+LATENCY+2. Back-to-back throughput is one request per LATENCY+2 cycles.
- Enables dropping during WAIT do not abort the request; completion is still signalled.

## Test plan
- Reset/clear: pulse rst for 1 cycle with ADDR_W=4 → busy high for 16 cycles, then 0. Reading every dword returns 32'h0 and rd_count=16 afterwards.
- RW merge: write 32'hAABBCCDD to dword 20 with byte_en=4'hF, then 32'h11223344 with byte_en=4'b0101 → a read returns 32'hAA22CC44. Done comes LATENCY cycles after acceptance, and wr_count=2.
- RO region: init write dword 0 = 32'h066610EE, then cfg write 32'hFFFFFFFF with byte_en=4'hF → done still pulses and a read returns 32'h066610EE.
- Latency sweep: LATENCY=1 and 15 with back-to-back reads to 0x3FF → done spacing is 3 and 17 cycles respectively. Done is exactly 1 cycle wide.
- Collisions: assert rd_en and wr_en together → err_both=1, the request is treated as a write, and rd_count is unchanged. Then a same-cycle init write and DONE write to dword 30 → the init data is stored.
- Mid-operation reset: assert rst during WAIT of a write to dword 40 → no done pulse, busy=1 for 2^ADDR_W cycles, dword 40 reads 0, and the counters are 0.
